// File: rtl/cm_loader_pkg.sv
// -----------------------------------------------------------------------------
// cm_loader_pkg
// Shared definitions for the configuration-memory loader.
//   CM_WORD_WIDTH : width of one cmem word, {op[23:0], routing[27:0]}
//   ADDR_LEN      : width of the configuration address
//   CM_LOCAL_SEL  : value of addr[18:17] that targets the local cmem
//   cm_state_e    : loader FSM states
//   cm_is_local() : decodes the local-cmem select field of an address
// -----------------------------------------------------------------------------
package cm_loader_pkg;

    localparam int CM_WORD_WIDTH = 52;
    localparam int ADDR_LEN      = 19;
    localparam int WORD_COUNT_W  = 4;

    localparam logic [1:0] CM_LOCAL_SEL = 2'b00;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        LOADED = 3'd2,
        ARM    = 3'd3,
        RUN    = 3'd4
    } cm_state_e;

    function automatic logic cm_is_local(input logic [ADDR_LEN-1:0] addr);
        return addr[ADDR_LEN-1 -: 2] == CM_LOCAL_SEL;
    endfunction

endpackage

// File: rtl/cm_loader_parity_chk.sv
// -----------------------------------------------------------------------------
// cm_parity_chk
// Combinational even-parity check of one configuration word. The sender's
// parity bit makes the total count of ones (data plus parity) even, so the
// word is good when the XOR-reduce of the data equals the parity bit.
// Ports:
//   data      in  CM_WORD_WIDTH  configuration word
//   parity    in  1              sender's even-parity bit
//   parity_ok out 1              1 when data and parity agree
// -----------------------------------------------------------------------------
module cm_parity_chk
    import cm_loader_pkg::*;
(
    input  logic [CM_WORD_WIDTH-1:0] data,
    input  logic                     parity,
    output logic                     parity_ok
);

    assign parity_ok = ((^data) == parity);

endmodule

// File: rtl/cm_loader.sv
// -----------------------------------------------------------------------------
// cm_loader
// Accepts configuration words over a valid/ready handshake and forwards them,
// registered, to the cmem port (RDWEN is active-low write). It also sequences a
// two-stage execute enable once start_exec is raised.
//
// Optional feature: define CM_LOADER_PARITY_EN to add cfg_parity / parity_err.
// Words failing the even-parity check are accepted but not written, and set
// the sticky parity_err flag.
//
// Ports:
//   clk                        in   sole clock, rising edge
//   rstn                       in   asynchronous active-low reset
//   chip_en                    in   global enable; 0 freezes the FSM
//   start_exec                 in   execute request (level)
//   cfg_valid / cfg_ready      in/out  word handshake
//   cfg_addr                   in   target address, [18:17]==00 -> local cmem
//   cfg_data / cfg_bit_en      in   word and bit enables
//   cfg_last                   in   final word of a load
//   wr_en_shifted              out  cmem RDWEN, 0 = write
//   cm_data_shifted            out  registered word
//   cm_bit_en_shifted          out  registered bit enables
//   address_out                out  registered address of last accepted word
//   start_exec_shifted         out  first execute stage (ARM and RUN)
//   start_exec_shifted_shifted out  second execute stage (RUN)
//   load_done                  out  a complete load is waiting for execute
//   word_count                 out  accepted words in current load, sat. 15
//   cfg_parity                 in   (CM_LOADER_PARITY_EN) even parity bit
//   parity_err                 out  (CM_LOADER_PARITY_EN) sticky error flag
// -----------------------------------------------------------------------------
module cm_loader
    import cm_loader_pkg::*;
(
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     chip_en,
    input  logic                     start_exec,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [ADDR_LEN-1:0]      cfg_addr,
    input  logic [CM_WORD_WIDTH-1:0] cfg_data,
    input  logic [CM_WORD_WIDTH-1:0] cfg_bit_en,
    input  logic                     cfg_last,
    output logic                     wr_en_shifted,
    output logic [CM_WORD_WIDTH-1:0] cm_data_shifted,
    output logic [CM_WORD_WIDTH-1:0] cm_bit_en_shifted,
    output logic [ADDR_LEN-1:0]      address_out,
    output logic                     start_exec_shifted,
    output logic                     start_exec_shifted_shifted,
    output logic                     load_done,
    output logic [WORD_COUNT_W-1:0]  word_count
`ifdef CM_LOADER_PARITY_EN
    ,
    input  logic                     cfg_parity,
    output logic                     parity_err
`endif
);

    cm_state_e                state_reg;
    cm_state_e                state_next;
    logic                     rst_done_reg;
    logic                     cfg_phase;
    logic                     xfer;
    logic                     word_ok;
    logic [WORD_COUNT_W-1:0]  word_count_reg;
    logic [WORD_COUNT_W-1:0]  word_count_next;
    logic                     wr_en_reg;
    logic [CM_WORD_WIDTH-1:0] data_reg;
    logic [CM_WORD_WIDTH-1:0] bit_en_reg;
    logic [ADDR_LEN-1:0]      addr_reg;

    // ---------------------------------------------------------------- parity
`ifdef CM_LOADER_PARITY_EN
    logic parity_err_reg;

    cm_parity_chk u_parity_chk (
        .data      (cfg_data),
        .parity    (cfg_parity),
        .parity_ok (word_ok)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            parity_err_reg <= 1'b0;
        end else if (xfer) begin
            // A bad word sets the flag even if it is also the first word of
            // a new load; otherwise starting a load from IDLE clears it.
            if (!word_ok) begin
                parity_err_reg <= 1'b1;
            end else if (state_reg == IDLE) begin
                parity_err_reg <= 1'b0;
            end
        end
    end

    assign parity_err = parity_err_reg;
`else
    assign word_ok = 1'b1;
`endif

    // ------------------------------------------------------------ handshake
    // rst_done_reg keeps cfg_ready low until the first edge after reset is
    // released, so no output can move before that edge. start_exec has
    // priority over a simultaneous word.
    assign cfg_phase = (state_reg == IDLE) || (state_reg == LOAD) || (state_reg == LOADED);
    assign cfg_ready = rst_done_reg & chip_en & ~start_exec & cfg_phase;
    assign xfer      = cfg_valid & cfg_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rst_done_reg <= 1'b0;
        end else begin
            rst_done_reg <= 1'b1;
        end
    end

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (chip_en) begin
            unique case (state_reg)
                IDLE, LOAD, LOADED: begin
                    if (start_exec) begin
                        state_next = ARM;
                    end else if (xfer) begin
                        state_next = cfg_last ? LOADED : LOAD;
                    end
                end
                ARM:     state_next = start_exec ? RUN : IDLE;
                RUN:     state_next = start_exec ? RUN : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // ----------------------------------------------------------- word count
    // A transfer from anywhere other than LOAD begins a new load.
    always_comb begin
        word_count_next = word_count_reg;
        if (xfer) begin
            if (state_reg == LOAD) begin
                word_count_next = (word_count_reg == {WORD_COUNT_W{1'b1}}) ?
                                  word_count_reg : word_count_reg + 1'b1;
            end else begin
                word_count_next = {{(WORD_COUNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word_count_reg <= '0;
        end else begin
            word_count_reg <= word_count_next;
        end
    end

    // ------------------------------------------------------------- datapath
    // The write strobe is a single-cycle pulse per accepted local word; data
    // and address hold their last value between transfers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_en_reg  <= 1'b1;
            data_reg   <= '0;
            bit_en_reg <= '0;
            addr_reg   <= '0;
        end else begin
            wr_en_reg <= 1'b1;
            if (xfer) begin
                data_reg   <= cfg_data;
                bit_en_reg <= cfg_bit_en;
                addr_reg   <= cfg_addr;
                wr_en_reg  <= ~(cm_is_local(cfg_addr) & word_ok);
            end
        end
    end

    // -------------------------------------------------------------- outputs
    assign wr_en_shifted              = wr_en_reg;
    assign cm_data_shifted            = data_reg;
    assign cm_bit_en_shifted          = bit_en_reg;
    assign address_out                = addr_reg;
    assign word_count                 = word_count_reg;
    assign load_done                  = (state_reg == LOADED);
    assign start_exec_shifted         = (state_reg == ARM) || (state_reg == RUN);
    assign start_exec_shifted_shifted = (state_reg == RUN);

endmodule
